map_probe_scheduler: RTL and testbench
======================================

# map_probe_scheduler

Shares a single wall-map lookup port between the two player characters' collision checks. On each frame the movement blocks post a probe request with their candidate centre position. The scheduler arbitrates round-robin and issues the four edge probes (up, down, left, right) back to back into the map port. It collects the pipelined results and hands each character a registered collision bundle with a one-cycle done strobe. It sits between the character movement blocks and one map lookup instance, replacing per-character map instances.

## Interface
Parameters:
- X_SIZE, 30: half-width of a character; horizontal probe offset.
- Y_SIZE, 30: half-height of a character; vertical probe offset.
- MAP_LAT, 1: map port read latency in cycles, ≥1.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  reset, asynchronous, active-low.
- req  in  2  per-character probe request pulse; bit k = character k (0 Fireboy, 1 Watergirl).
- pos_x0, pos_y0  in  10 each  character 0 candidate centre, sampled when req[0] is accepted.
- pos_x1, pos_y1  in  10 each  character 1 candidate centre, sampled when req[1] is accepted.
- map_valid  out  1  a probe is issued this cycle.
- map_x, map_y  out  10 each  probe coordinate.
- map_is_wall  in  1  wall hit, returned MAP_LAT cycles after map_valid.
- map_x_bias, map_y_bias  in  10 each  penetration depth, same timing as map_is_wall.
- done  out  2  one-cycle strobe: bundle k updated.
- wall0, wall1  out  4 each  hit flags {right,left,down,up}.
- bias_up0/1, bias_down0/1  out  10 each  y-bias per character.
- bias_left0/1, bias_right0/1  out  10 each  x-bias per character.
- busy  out  1  state ≠ IDLE.
- overrun  out  2  one-cycle strobe: req[k] dropped.

## Operation
- Request acceptance:
  - req[k] is accepted when pending[k]=0 and character k is not in ISSUE or DRAIN.
  - On acceptance, pending[k] is set and the position is captured into a per-character register.
  - Otherwise the request is dropped and overrun[k] pulses.
- FSM states:
  - IDLE → ISSUE when any pending is set. Grant goes to the pending character ≠ last_grant if both are set; otherwise to the only one. Grant clears pending[g].
  - ISSUE: 2-bit dir counter 0..3 (up, down, left, right). map_valid=1 on each of 4 consecutive cycles. After dir=3 → DRAIN.
  - DRAIN: waits until the last result returns → DONE.
  - DONE: one cycle. Copies the shadow bundle into the output registers of character g and asserts done[g]. Then goes to ISSUE directly if another grant is available, else IDLE.
- Probe coordinates (mod 1024, no saturation):
  - up (x, y−Y_SIZE)
  - down (x, y+Y_SIZE)
  - left (x−X_SIZE, y)
  - right (x+X_SIZE, y)
- Result capture:
  - A MAP_LAT-deep tag pipe carries {valid, dir}. On return, flag[dir] ← map_is_wall.
  - Bias ← map_y_bias for up/down and map_x_bias for left/right; forced to 0 when map_is_wall=0.
  - Results are written to the shadow registers only, so outputs change atomically at DONE.
- Reset:
  - All outputs 0; pending 0; last_grant=1, so character 0 wins the first tie.
  - State IDLE; tag pipe cleared.
  - Asserting reset mid-probe aborts immediately and drops map_valid asynchronously.

## Timing
- req[k] accepted in cycle t while IDLE → map_valid in t+1..t+4 → done[k] in cycle t+5+MAP_LAT, with outputs valid the same cycle.
- Back-to-back service: the second character's first probe issues in the cycle after the first character's DONE. A two-character frame takes 2×(5+MAP_LAT) cycles worst case.
- req[g] arriving in the DONE cycle of g is accepted.
- Simultaneous req[0] and req[1] while IDLE: both accepted; round-robin decides the order.
- Output bundles hold their value until the next done for that character.

## Structure
- Package map_probe_pkg holds:
  - state_t enum {IDLE, ISSUE, DRAIN, DONE};
  - dir_t enum {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
  - the flag bit indices;
  - the probe_bundle_t struct (flags plus four biases).
- Sub-module probe_tag_pipe: MAP_LAT-stage shift register of {valid, dir}, async active-low clear.

## Test plan
- Single request: req=2'b01, pos (320,240), map model reports wall only at y=270 with y_bias=5, MAP_LAT=1. Required: probe coordinates (320,210), (320,270), (290,240), (350,240); done[0] 6 cycles after req; wall0=4'b0010, bias_down0=5, all other biases 0.
- Tie: req=2'b11 with last_grant=1 after reset. Required: character 0 served first; done[0] at t+6 and done[1] at t+12.
- Overrun: req[1] pulsed twice while character 1 is in ISSUE. Required: overrun[1] pulses once per dropped request; only one done[1].
- Wrap-around: pos (10,5). Required: up probe y=999 and left probe x=1004 (mod 1024).
- Reset mid-ISSUE: drop Reset_n on the 2nd probe cycle. Required: map_valid=0 immediately; no done; outputs 0; next request is served normally.
- MAP_LAT=3: single request. Required: done 8 cycles after req; flags land in the correct dir slots.

Source files
------------

// File: rtl/map_probe_pkg.sv
// Shared types for the map probe scheduler: FSM states, probe directions,
// hit-flag bit positions and the per-character collision bundle.
package map_probe_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam int FLAG_UP    = 0;
  localparam int FLAG_DOWN  = 1;
  localparam int FLAG_LEFT  = 2;
  localparam int FLAG_RIGHT = 3;

  typedef struct packed {
    logic [3:0] flags;
    logic [9:0] bias_up;
    logic [9:0] bias_down;
    logic [9:0] bias_left;
    logic [9:0] bias_right;
  } probe_bundle_t;

endpackage

// File: rtl/probe_tag_pipe.sv
// Delays the {valid, dir} tag of each issued probe by the map read latency
// so returning results can be steered into the right flag/bias slot.
module probe_tag_pipe #(
  parameter int LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [1:0] dir_i,
  output logic       valid_o,
  output logic [1:0] dir_o
);

  logic [LAT-1:0] valid_q;
  logic [1:0]     dir_q [LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) dir_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      dir_q[0]   <= dir_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        dir_q[i]   <= dir_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign dir_o   = dir_q[LAT-1];

endmodule

// File: rtl/map_probe_scheduler.sv
// Time-shares one wall-map lookup port between the two characters: round-robin
// grant, four back-to-back edge probes, atomic per-character result bundles.
module map_probe_scheduler
  import map_probe_pkg::*;
#(
  parameter int X_SIZE  = 30,
  parameter int Y_SIZE  = 30,
  parameter int MAP_LAT = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [1:0] req,
  input  logic [9:0] pos_x0,
  input  logic [9:0] pos_y0,
  input  logic [9:0] pos_x1,
  input  logic [9:0] pos_y1,
  output logic       map_valid,
  output logic [9:0] map_x,
  output logic [9:0] map_y,
  input  logic       map_is_wall,
  input  logic [9:0] map_x_bias,
  input  logic [9:0] map_y_bias,
  output logic [1:0] done,
  output logic [3:0] wall0,
  output logic [3:0] wall1,
  output logic [9:0] bias_up0,
  output logic [9:0] bias_up1,
  output logic [9:0] bias_down0,
  output logic [9:0] bias_down1,
  output logic [9:0] bias_left0,
  output logic [9:0] bias_left1,
  output logic [9:0] bias_right0,
  output logic [9:0] bias_right1,
  output logic       busy,
  output logic [1:0] overrun
);

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [1:0]    pending_q, pending_d;
  logic [9:0]    pos_x_q [2];
  logic [9:0]    pos_y_q [2];
  probe_bundle_t shadow_q, shadow_d;
  probe_bundle_t bundle_q [2];
  logic [1:0]    done_q, overrun_q;

  logic       serving;
  logic [1:0] accept, eff_pending;
  logic       pick, start, load_out;
  logic       tag_valid;
  logic [1:0] tag_dir_raw;
  dir_t       tag_dir;
  logic [9:0] cx, cy;
  logic [9:0] hit_bias_x, hit_bias_y;

  // The character currently being probed cannot queue a second request;
  // it becomes eligible again in its own DONE cycle.
  assign serving     = (state_q == ISSUE) || (state_q == DRAIN);
  assign accept[0]   = req[0] & ~pending_q[0] & ~(serving & ~grant_q);
  assign accept[1]   = req[1] & ~pending_q[1] & ~(serving & grant_q);
  assign eff_pending = pending_q | accept;
  assign pick        = (&eff_pending) ? ~last_grant_q : eff_pending[1];

  assign tag_dir    = dir_t'(tag_dir_raw);
  assign hit_bias_x = map_is_wall ? map_x_bias : 10'd0;
  assign hit_bias_y = map_is_wall ? map_y_bias : 10'd0;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pending_d    = eff_pending;
    shadow_d     = shadow_q;
    start        = 1'b0;
    load_out     = 1'b0;

    if (tag_valid) begin
      case (tag_dir)
        DIR_UP: begin
          shadow_d.flags[FLAG_UP] = map_is_wall;
          shadow_d.bias_up        = hit_bias_y;
        end
        DIR_DOWN: begin
          shadow_d.flags[FLAG_DOWN] = map_is_wall;
          shadow_d.bias_down        = hit_bias_y;
        end
        DIR_LEFT: begin
          shadow_d.flags[FLAG_LEFT] = map_is_wall;
          shadow_d.bias_left        = hit_bias_x;
        end
        default: begin
          shadow_d.flags[FLAG_RIGHT] = map_is_wall;
          shadow_d.bias_right        = hit_bias_x;
        end
      endcase
    end

    case (state_q)
      IDLE:  start = |eff_pending;
      ISSUE: begin
        dir_d = dir_t'(dir_q + 2'd1);
        if (dir_q == DIR_RIGHT) state_d = DRAIN;
      end
      DRAIN: begin
        if (tag_valid && tag_dir == DIR_RIGHT) begin
          state_d  = DONE;
          load_out = 1'b1;
        end
      end
      DONE: begin
        start = |eff_pending;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d         = ISSUE;
      dir_d           = DIR_UP;
      grant_d         = pick;
      last_grant_d    = pick;
      pending_d[pick] = 1'b0;
    end
  end

  assign cx = grant_q ? pos_x_q[1] : pos_x_q[0];
  assign cy = grant_q ? pos_y_q[1] : pos_y_q[0];

  // Coordinates wrap modulo 1024 by plain 10-bit arithmetic.
  always_comb begin
    map_x = cx;
    map_y = cy;
    case (dir_q)
      DIR_UP:    map_y = cy - 10'(Y_SIZE);
      DIR_DOWN:  map_y = cy + 10'(Y_SIZE);
      DIR_LEFT:  map_x = cx - 10'(X_SIZE);
      default:   map_x = cx + 10'(X_SIZE);
    endcase
  end

  assign map_valid = (state_q == ISSUE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      dir_q        <= DIR_UP;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pending_q    <= 2'b00;
      shadow_q     <= '0;
      done_q       <= 2'b00;
      overrun_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      done_q       <= load_out ? {grant_q, ~grant_q} : 2'b00;
      overrun_q    <= req & ~accept;
    end
  end

  // Output bundles load with the final result merged in, so done and data
  // become visible together and hold until the next service.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < 2; k++) begin
        pos_x_q[k]  <= '0;
        pos_y_q[k]  <= '0;
        bundle_q[k] <= '0;
      end
    end else begin
      if (accept[0]) begin
        pos_x_q[0] <= pos_x0;
        pos_y_q[0] <= pos_y0;
      end
      if (accept[1]) begin
        pos_x_q[1] <= pos_x1;
        pos_y_q[1] <= pos_y1;
      end
      if (load_out) bundle_q[grant_q] <= shadow_d;
    end
  end

  probe_tag_pipe #(
    .LAT(MAP_LAT)
  ) u_tag_pipe (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .valid_i(map_valid),
    .dir_i  (dir_q),
    .valid_o(tag_valid),
    .dir_o  (tag_dir_raw)
  );

  assign done        = done_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);
  assign wall0       = bundle_q[0].flags;
  assign wall1       = bundle_q[1].flags;
  assign bias_up0    = bundle_q[0].bias_up;
  assign bias_up1    = bundle_q[1].bias_up;
  assign bias_down0  = bundle_q[0].bias_down;
  assign bias_down1  = bundle_q[1].bias_down;
  assign bias_left0  = bundle_q[0].bias_left;
  assign bias_left1  = bundle_q[1].bias_left;
  assign bias_right0 = bundle_q[0].bias_right;
  assign bias_right1 = bundle_q[1].bias_right;

endmodule

// File: tb/tb_map_probe_scheduler.sv
// Randomized self-checking bench for map_probe_scheduler with a behavioural
// wall map and reference model; a second instance covers MAP_LAT=3.
module tb_map_probe_scheduler;

  localparam int XS = 30;
  localparam int YS = 30;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  int         cyc = 0;

  logic [1:0] req;
  logic [9:0] posX0, posY0, posX1, posY1;
  logic       mapValid, mapIsWall;
  logic [9:0] mapX, mapY, mapXBias, mapYBias;
  logic [1:0] done, overrun;
  logic [3:0] wall0, wall1;
  logic [9:0] biasUp0, biasUp1, biasDown0, biasDown1;
  logic [9:0] biasLeft0, biasLeft1, biasRight0, biasRight1;
  logic       busy;

  logic [1:0] reqB;
  logic [9:0] posX0B, posY0B;
  logic       mapValidB, mapIsWallB;
  logic [9:0] mapXB, mapYB;
  logic [1:0] doneB, overrunB;
  logic [3:0] wall0B, wall1B;
  logic [9:0] biasUp0B, biasUp1B, biasDown0B, biasDown1B;
  logic [9:0] biasLeft0B, biasLeft1B, biasRight0B, biasRight1B;
  logic       busyB;

  int         wallX = 2000, wallY = 2000;
  logic [9:0] xBias = '0, yBias = '0;

  int assertCount = 0;
  int failCount   = 0;
  int reqCyc      = 0;

  int doneCnt [2] = '{0, 0};
  int doneCyc [2] = '{0, 0};
  int ovCnt   [2] = '{0, 0};
  int doneCntB = 0, doneCycB = 0;
  logic [19:0] probeQ [$];

  logic [3:0] expFlags [2];
  logic [9:0] expBias  [2][4];
  logic [9:0] expPx    [2][4];
  logic [9:0] expPy    [2][4];

  map_probe_scheduler #(.X_SIZE(XS), .Y_SIZE(YS), .MAP_LAT(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req),
    .pos_x0(posX0), .pos_y0(posY0), .pos_x1(posX1), .pos_y1(posY1),
    .map_valid(mapValid), .map_x(mapX), .map_y(mapY),
    .map_is_wall(mapIsWall), .map_x_bias(mapXBias), .map_y_bias(mapYBias),
    .done(done), .wall0(wall0), .wall1(wall1),
    .bias_up0(biasUp0), .bias_up1(biasUp1), .bias_down0(biasDown0), .bias_down1(biasDown1),
    .bias_left0(biasLeft0), .bias_left1(biasLeft1), .bias_right0(biasRight0), .bias_right1(biasRight1),
    .busy(busy), .overrun(overrun)
  );

  map_probe_scheduler #(.X_SIZE(XS), .Y_SIZE(YS), .MAP_LAT(3)) dutLat3 (
    .Clk(Clk), .Reset_n(Reset_n), .req(reqB),
    .pos_x0(posX0B), .pos_y0(posY0B), .pos_x1(10'd0), .pos_y1(10'd0),
    .map_valid(mapValidB), .map_x(mapXB), .map_y(mapYB),
    .map_is_wall(mapIsWallB), .map_x_bias(xBias), .map_y_bias(yBias),
    .done(doneB), .wall0(wall0B), .wall1(wall1B),
    .bias_up0(biasUp0B), .bias_up1(biasUp1B), .bias_down0(biasDown0B), .bias_down1(biasDown1B),
    .bias_left0(biasLeft0B), .bias_left1(biasLeft1B), .bias_right0(biasRight0B), .bias_right1(biasRight1B),
    .busy(busyB), .overrun(overrunB)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural wall map: a wall is any cell on column wallX or row wallY.
  // Bias inputs stay nonzero even on a miss so masking gets exercised.
  logic       hvA = 1'b0;
  logic [9:0] hxA = '0, hyA = '0;
  logic       hvB [3] = '{1'b0, 1'b0, 1'b0};
  logic [9:0] hxB [3] = '{10'd0, 10'd0, 10'd0};
  logic [9:0] hyB [3] = '{10'd0, 10'd0, 10'd0};

  always @(posedge Clk) begin
    hvA    <= mapValid;
    hxA    <= mapX;
    hyA    <= mapY;
    hvB[0] <= mapValidB;
    hxB[0] <= mapXB;
    hyB[0] <= mapYB;
    for (int i = 1; i < 3; i++) begin
      hvB[i] <= hvB[i-1];
      hxB[i] <= hxB[i-1];
      hyB[i] <= hyB[i-1];
    end
  end

  assign mapIsWall  = hvA && ((int'(hxA) == wallX) || (int'(hyA) == wallY));
  assign mapIsWallB = hvB[2] && ((int'(hxB[2]) == wallX) || (int'(hyB[2]) == wallY));
  assign mapXBias   = xBias;
  assign mapYBias   = yBias;

  always @(negedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done[k]) begin
        doneCnt[k] <= doneCnt[k] + 1;
        doneCyc[k] <= cyc;
      end
      if (overrun[k]) ovCnt[k] <= ovCnt[k] + 1;
    end
    if (doneB[0]) begin
      doneCntB <= doneCntB + 1;
      doneCycB <= cyc;
    end
    if (mapValid) probeQ.push_back({mapX, mapY});
  end

  function automatic int wrap(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: four edge probes from the centre, hit if on the wall row or
  // column; up/down report the y bias, left/right the x bias.
  task automatic computeExpected(input int k, input int x, input int y);
    int px, py;
    logic hit;
    for (int d = 0; d < 4; d++) begin
      px = (d == 2) ? wrap(x - XS) : (d == 3) ? wrap(x + XS) : x;
      py = (d == 0) ? wrap(y - YS) : (d == 1) ? wrap(y + YS) : y;
      hit = (px == wallX) || (py == wallY);
      expPx[k][d]    = 10'(px);
      expPy[k][d]    = 10'(py);
      expFlags[k][d] = hit;
      expBias[k][d]  = hit ? ((d < 2) ? yBias : xBias) : 10'd0;
    end
  endtask

  task automatic checkBundle(input int k);
    logic [3:0] f;
    logic [9:0] b [4];
    if (k == 0) begin
      f = wall0; b[0] = biasUp0; b[1] = biasDown0; b[2] = biasLeft0; b[3] = biasRight0;
    end else begin
      f = wall1; b[0] = biasUp1; b[1] = biasDown1; b[2] = biasLeft1; b[3] = biasRight1;
    end
    checkOutput($sformatf("wall%0d", k), 32'(f), 32'(expFlags[k]));
    for (int d = 0; d < 4; d++)
      checkOutput($sformatf("bias%0d_dir%0d", k, d), 32'(b[d]), 32'(expBias[k][d]));
  endtask

  task automatic checkProbes(input int k, input int base);
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("probeX%0d_dir%0d", k, d), 32'(probeQ[base+d][19:10]), 32'(expPx[k][d]));
      checkOutput($sformatf("probeY%0d_dir%0d", k, d), 32'(probeQ[base+d][9:0]), 32'(expPy[k][d]));
    end
  endtask

  // Called just after a rising edge; holds req for exactly one cycle.
  task automatic applyStimulus(input logic [1:0] r, input int x0, input int y0, input int x1, input int y1);
    posX0  = 10'(x0);
    posY0  = 10'(y0);
    posX1  = 10'(x1);
    posY1  = 10'(y1);
    req    = r;
    reqCyc = cyc;
    @(posedge Clk);
    #1;
    req = 2'b00;
  endtask

  task automatic waitDone(input int k);
    int start;
    int n;
    start = doneCnt[k];
    n = 0;
    while (doneCnt[k] == start && n < 80) begin
      @(negedge Clk);
      n++;
    end
    if (doneCnt[k] == start) checkOutput($sformatf("doneTimeout%0d", k), 32'd0, 32'd1);
  endtask

  task automatic serveCheck(input int k, input int x, input int y);
    int ox, oy;
    ox = $urandom_range(0, 1023);
    oy = $urandom_range(0, 1023);
    computeExpected(k, x, y);
    probeQ.delete();
    if (k == 0) applyStimulus(2'b01, x, y, ox, oy);
    else        applyStimulus(2'b10, ox, oy, x, y);
    checkOutput("busyAfterReq", 32'(busy), 32'd1);
    checkOutput("mapValidAfterReq", 32'(mapValid), 32'd1);
    waitDone(k);
    checkOutput($sformatf("latency%0d", k), 32'(doneCyc[k] - reqCyc), 32'd6);
    checkOutput("probeCount", 32'(probeQ.size()), 32'd4);
    checkProbes(k, 0);
    checkBundle(0);
    checkBundle(1);
    @(posedge Clk);
    #1;
    checkOutput("idleAfterDone", 32'(busy), 32'd0);
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int x0, y0, x1, y1, doneBefore, ovBefore0, ovBefore1;
    req = '0; posX0 = '0; posY0 = '0; posX1 = '0; posY1 = '0;
    reqB = '0; posX0B = '0; posY0B = '0;
    for (int k = 0; k < 2; k++) begin
      expFlags[k] = '0;
      for (int d = 0; d < 4; d++) expBias[k][d] = '0;
    end

    repeat (3) @(posedge Clk);
    #1;
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstOverrun", 32'(overrun), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstMapValid", 32'(mapValid), 32'd0);
    checkBundle(0);
    checkBundle(1);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Directed single request: wall row at y=270 only.
    wallX = 2000; wallY = 270; yBias = 10'd5; xBias = 10'd9;
    serveCheck(0, 320, 240);
    checkOutput("singleWall0", 32'(wall0), 32'b0010);
    checkOutput("singleBiasDown0", 32'(biasDown0), 32'd5);

    // Coordinate wrap-around.
    wallX = 2000; wallY = 2000;
    serveCheck(1, 10, 5);
    checkOutput("wrapUpY", 32'(probeQ[0][9:0]), 32'd999);
    checkOutput("wrapLeftX", 32'(probeQ[2][19:10]), 32'd1004);

    // Reset during the second probe cycle.
    wallX = 2000; wallY = 270;
    doneBefore = doneCnt[0];
    applyStimulus(2'b01, 320, 240, 0, 0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("midRstMapValid", 32'(mapValid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    checkOutput("midRstNoDone", 32'(doneCnt[0] - doneBefore), 32'd0);
    for (int k = 0; k < 2; k++) begin
      expFlags[k] = '0;
      for (int d = 0; d < 4; d++) expBias[k][d] = '0;
    end
    checkBundle(0);
    checkBundle(1);

    // Simultaneous requests right after reset: character 0 wins the tie.
    x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 1023);
    x1 = $urandom_range(0, 1023); y1 = $urandom_range(0, 1023);
    wallX = wrap(x0 - XS); wallY = wrap(y1 + YS);
    xBias = 10'($urandom_range(1, 1023)); yBias = 10'($urandom_range(1, 1023));
    computeExpected(0, x0, y0);
    computeExpected(1, x1, y1);
    probeQ.delete();
    applyStimulus(2'b11, x0, y0, x1, y1);
    waitDone(0);
    checkOutput("tieLatency0", 32'(doneCyc[0] - reqCyc), 32'd6);
    waitDone(1);
    checkOutput("tieLatency1", 32'(doneCyc[1] - reqCyc), 32'd12);
    checkOutput("tieProbeCount", 32'(probeQ.size()), 32'd8);
    checkProbes(0, 0);
    checkProbes(1, 4);
    checkBundle(0);
    checkBundle(1);
    @(posedge Clk);
    #1;

    // Randomized single services.
    for (int n = 0; n < 8; n++) begin
      int k, x, y;
      k = $urandom_range(0, 1);
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
      case ($urandom_range(0, 3))
        0: wallY = wrap(y - YS);
        1: wallY = wrap(y + YS);
        2: wallY = y;
        default: wallY = 2000;
      endcase
      case ($urandom_range(0, 3))
        0: wallX = wrap(x - XS);
        1: wallX = wrap(x + XS);
        2: wallX = x;
        default: wallX = 2000;
      endcase
      xBias = 10'($urandom_range(1, 1023));
      yBias = 10'($urandom_range(1, 1023));
      serveCheck(k, x, y);
    end

    // Two requests from character 1 while it is being probed are dropped.
    x1 = $urandom_range(0, 1023); y1 = $urandom_range(0, 1023);
    wallX = wrap(x1 + XS); wallY = wrap(y1 - YS);
    computeExpected(1, x1, y1);
    probeQ.delete();
    ovBefore0 = ovCnt[0];
    ovBefore1 = ovCnt[1];
    doneBefore = doneCnt[1];
    applyStimulus(2'b10, 0, 0, x1, y1);
    req = 2'b10; posX1 = 10'(wrap(x1 + 111)); posY1 = 10'(wrap(y1 + 222));
    @(posedge Clk); #1; req = 2'b00;
    @(posedge Clk); #1; req = 2'b10;
    @(posedge Clk); #1; req = 2'b00;
    waitDone(1);
    checkOutput("ovrLatency", 32'(doneCyc[1] - reqCyc), 32'd6);
    repeat (10) @(posedge Clk);
    #1;
    checkOutput("overrunPulses1", 32'(ovCnt[1] - ovBefore1), 32'd2);
    checkOutput("overrunPulses0", 32'(ovCnt[0] - ovBefore0), 32'd0);
    checkOutput("ovrSingleDone", 32'(doneCnt[1] - doneBefore), 32'd1);
    checkOutput("ovrProbeCount", 32'(probeQ.size()), 32'd4);
    checkBundle(1);

    // MAP_LAT=3 instance: down and left probes hit.
    wallX = 290; wallY = 270;
    xBias = 10'($urandom_range(1, 1023)); yBias = 10'($urandom_range(1, 1023));
    posX0B = 10'd320; posY0B = 10'd240;
    doneBefore = doneCntB;
    reqB = 2'b01;
    reqCyc = cyc;
    @(posedge Clk); #1; reqB = 2'b00;
    for (int n = 0; n < 80 && doneCntB == doneBefore; n++) @(negedge Clk);
    if (doneCntB == doneBefore) checkOutput("lat3Timeout", 32'd0, 32'd1);
    checkOutput("lat3Latency", 32'(doneCycB - reqCyc), 32'd8);
    checkOutput("lat3Wall0", 32'(wall0B), 32'b0110);
    checkOutput("lat3BiasUp", 32'(biasUp0B), 32'd0);
    checkOutput("lat3BiasDown", 32'(biasDown0B), 32'(yBias));
    checkOutput("lat3BiasLeft", 32'(biasLeft0B), 32'(xBias));
    checkOutput("lat3BiasRight", 32'(biasRight0B), 32'd0);
    checkOutput("lat3Wall1", 32'(wall1B), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
